// File: rtl/spi_xfer_ctrl.sv
// SPI master word-transfer controller: sequences chip select, MOSI/MISO shifting
// and SCLK gating on top of an external baud rate generator's strobe/rise/fall pulses.
module spi_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int EDGE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_ready_o,
    input  logic              lsb_first_i,
    input  logic              cpha_i,
    input  logic              abort_i,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              brg_en_o,
    output logic              brg_sclk_en_o,
    input  logic              brg_strobe_i,
    input  logic              brg_rise_i,
    input  logic              brg_fall_i,
    output logic              cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [EDGE_W-1:0] ZERO_EDGE = EDGE_W'(0);
    localparam logic [EDGE_W-1:0] ONE_EDGE  = EDGE_W'(1);

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
    endfunction

    // Receive direction mirrors transmit so the first bit on the wire lands in its own position.
    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] d, input logic b,
                                                   input logic lsb);
        return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
    endfunction

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                brg_en_q, brg_en_d;
    logic                sclk_en_q, sclk_en_d;
    logic                rx_valid_q, rx_valid_d;
    logic                edge_s;
    logic [DATA_W-1:0]   tx_next_s;

    assign edge_s    = brg_strobe_i && sclk_en_q;
    assign tx_next_s = shift_tx(tx_shift_q, lsb_q);

    // Next-state and output decode; abort outranks the normal sequencing.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        edge_cnt_d = edge_cnt_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        brg_en_d   = brg_en_q;
        sclk_en_d  = sclk_en_q;
        rx_valid_d = 1'b0;
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cs_n_d    = 1'b1;
            brg_en_d  = 1'b0;
            sclk_en_d = 1'b0;
            mosi_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid_i) begin
                        tx_shift_d = tx_data_i;
                        cpha_d     = cpha_i;
                        lsb_d      = lsb_first_i;
                        cs_n_d     = 1'b0;
                        brg_en_d   = 1'b1;
                        mosi_d     = first_bit(tx_data_i, lsb_first_i);
                        state_d    = ST_SETUP;
                    end else begin
                        cs_n_d = 1'b1;
                    end
                end
                ST_SETUP: begin
                    // This strobe is swallowed to give half a period of CS-to-SCLK setup.
                    if (brg_strobe_i) begin
                        sclk_en_d  = 1'b1;
                        edge_cnt_d = ZERO_EDGE;
                        state_d    = ST_XFER;
                    end else begin
                        sclk_en_d = 1'b0;
                    end
                end
                ST_XFER: begin
                    if (edge_s) begin
                        edge_cnt_d = edge_cnt_q + ONE_EDGE;
                        if (brg_rise_i) begin
                            if (!cpha_q) begin
                                rx_shift_d = shift_rx(rx_shift_q, miso_i, lsb_q);
                            end else if (edge_cnt_q != ZERO_EDGE) begin
                                tx_shift_d = tx_next_s;
                                mosi_d     = first_bit(tx_next_s, lsb_q);
                            end else begin
                                mosi_d = mosi_q;
                            end
                        end else if (brg_fall_i) begin
                            if (cpha_q) begin
                                rx_shift_d = shift_rx(rx_shift_q, miso_i, lsb_q);
                            end else if (edge_cnt_q != LAST_EDGE) begin
                                tx_shift_d = tx_next_s;
                                mosi_d     = first_bit(tx_next_s, lsb_q);
                            end else begin
                                mosi_d = mosi_q;
                            end
                        end else begin
                            mosi_d = mosi_q;
                        end
                        if (edge_cnt_q == LAST_EDGE) begin
                            sclk_en_d = 1'b0;
                            state_d   = ST_HOLD;
                        end else begin
                            state_d = ST_XFER;
                        end
                    end else begin
                        state_d = ST_XFER;
                    end
                end
                ST_HOLD: begin
                    if (brg_strobe_i) begin
                        cs_n_d     = 1'b1;
                        brg_en_d   = 1'b0;
                        mosi_d     = 1'b0;
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cs_n_d    = 1'b1;
                    brg_en_d  = 1'b0;
                    sclk_en_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            edge_cnt_q <= ZERO_EDGE;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            brg_en_q   <= 1'b0;
            sclk_en_q  <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            edge_cnt_q <= edge_cnt_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            brg_en_q   <= brg_en_d;
            sclk_en_q  <= sclk_en_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready_o    = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign rx_valid_o    = rx_valid_q;
    assign rx_data_o     = rx_data_q;
    assign brg_en_o      = brg_en_q;
    assign brg_sclk_en_o = sclk_en_q;
    assign cs_n_o        = cs_n_q;
    assign mosi_o        = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl with a behavioural baud generator and SPI slave model.
module tb_spi_xfer_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, tx_valid = 1'b0, lsb_first = 1'b0, cpha = 1'b0, abort = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         miso;
    logic         tx_ready, rx_valid, busy, brg_en, brg_sclk_en, cs_n, mosi;
    logic [W-1:0] rx_data;

    // Generator model: strobe every g_sel+1 cycles while enabled; SCLK toggles only with sclk_en.
    logic       g_strobe = 1'b0, g_rise = 1'b0, g_fall = 1'b0, g_sclk = 1'b0;
    logic [3:0] g_cnt = 4'd0, g_sel = 4'd1;

    spi_xfer_ctrl #(.DATA_W(W), .EDGE_W(6)) dut (
        .clk(clk), .rst(rst),
        .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
        .lsb_first_i(lsb_first), .cpha_i(cpha), .abort_i(abort),
        .rx_valid_o(rx_valid), .rx_data_o(rx_data), .busy_o(busy),
        .brg_en_o(brg_en), .brg_sclk_en_o(brg_sclk_en),
        .brg_strobe_i(g_strobe), .brg_rise_i(g_rise), .brg_fall_i(g_fall),
        .cs_n_o(cs_n), .mosi_o(mosi), .miso_i(miso)
    );

    always @(posedge clk) begin
        if (rst || !brg_en) begin
            g_cnt <= 4'd0; g_strobe <= 1'b0; g_rise <= 1'b0; g_fall <= 1'b0; g_sclk <= 1'b0;
        end else if (g_cnt == g_sel) begin
            g_cnt    <= 4'd0;
            g_strobe <= 1'b1;
            g_rise   <= brg_sclk_en && !g_sclk;
            g_fall   <= brg_sclk_en && g_sclk;
            if (brg_sclk_en) g_sclk <= ~g_sclk;
        end else begin
            g_cnt <= g_cnt + 4'd1; g_strobe <= 1'b0; g_rise <= 1'b0; g_fall <= 1'b0;
        end
    end

    // Slave model: presents s_word bits, advancing on its launch edge.
    logic         s_cpha = 1'b0, s_lsb = 1'b0, s_loop = 1'b1;
    logic [W-1:0] s_word = '0;
    int           s_idx = 0, s_rises = 0;

    always @(posedge clk) begin
        if (rst || cs_n) begin
            s_idx <= 0; s_rises <= 0;
        end else begin
            if (g_rise) s_rises <= s_rises + 1;
            if (!s_cpha && g_fall) s_idx <= s_idx + 1;
            if (s_cpha && g_rise && s_rises != 0) s_idx <= s_idx + 1;
        end
    end

    function automatic logic slave_bit(input logic [W-1:0] w, input int idx, input logic lsb);
        if (idx >= W) return 1'b0;
        return lsb ? w[idx] : w[W-1-idx];
    endfunction

    assign miso = s_loop ? mosi : slave_bit(s_word, s_idx, s_lsb);

    // Monitor on the falling edge: running totals that tests difference against snapshots.
    int           rxv_total = 0, rise_total = 0, fall_total = 0, cs_low_total = 0, ready_bad = 0;
    int           hi_run = 0, last_gap = 999;
    logic         prev_cs_n = 1'b1;
    logic [W-1:0] last_rx = '0, mosi_word = '0;

    always @(negedge clk) begin
        if (rx_valid) begin rxv_total = rxv_total + 1; last_rx = rx_data; end
        if (g_rise) rise_total = rise_total + 1;
        if (g_fall) fall_total = fall_total + 1;
        if (!cs_n) cs_low_total = cs_low_total + 1;
        if (!cs_n && tx_ready) ready_bad = ready_bad + 1;
        if (s_cpha ? g_fall : g_rise)
            mosi_word = s_lsb ? {mosi, mosi_word[W-1:1]} : {mosi_word[W-2:0], mosi};
        if (cs_n) hi_run = hi_run + 1;
        else begin
            if (prev_cs_n) last_gap = hi_run;
            hi_run = 0;
        end
        prev_cs_n = cs_n;
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         lsb;
        logic         cpha;
        logic         loop;
        logic [W-1:0] sword;
        int           p;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs[5];
    int   rxv0, rise0, fall0, cs0, bad0;
    logic [W-1:0] prev_exp = '0;

    task automatic start(input vec_t v);
        g_sel = 4'(v.p - 1); s_cpha = v.cpha; s_lsb = v.lsb; s_loop = v.loop; s_word = v.sword;
        rxv0 = rxv_total; rise0 = rise_total; fall0 = fall_total; cs0 = cs_low_total; bad0 = ready_bad;
        tx_data = v.data; lsb_first = v.lsb; cpha = v.cpha; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic finish(input string tag, input vec_t v, input bit toggle);
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(posedge clk); #1;
            if (rxv_total != rxv0) done = 1'b1;
            else if (toggle) begin
                tx_data = W'($urandom); cpha = ~cpha; lsb_first = ~lsb_first;
            end
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_rx_data"}, 32'(rx_data), 32'(v.exp_rx));
        check({tag, "_rx_valid_pulses"}, 32'(rxv_total - rxv0), 32'd1);
        check({tag, "_rises"}, 32'(rise_total - rise0), 32'(W));
        check({tag, "_falls"}, 32'(fall_total - fall0), 32'(W));
        check({tag, "_mosi_word"}, 32'(mosi_word), 32'(v.data));
        check({tag, "_cs_low_cycles"}, 32'(cs_low_total - cs0), 32'((2 * W + 2) * v.p + 1));
        check({tag, "_tx_ready_while_cs"}, 32'(ready_bad - bad0), 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        prev_exp = v.exp_rx;
    endtask

    task automatic do_xfer(input string tag, input vec_t v, input bit toggle);
        start(v);
        finish(tag, v, toggle);
    endtask

    task automatic wait_edges(input int n);
        int e0 = rise_total + fall_total;
        for (int i = 0; i < 2000 && (rise_total + fall_total - e0) < n; i++) begin
            @(posedge clk); #1;
        end
        check("edge_wait", {31'd0, ((rise_total + fall_total - e0) >= n)}, 32'd1);
    endtask

    vec_t v;
    bit   ok;

    initial begin
        vecs[0] = '{data: 8'hA5, lsb: 1'b0, cpha: 1'b0, loop: 1'b1, sword: 8'h00, p: 2, exp_rx: 8'hA5};
        vecs[1] = '{data: 8'h3C, lsb: 1'b1, cpha: 1'b1, loop: 1'b0, sword: 8'h96, p: 2, exp_rx: 8'h96};
        vecs[2] = '{data: 8'h81, lsb: 1'b0, cpha: 1'b1, loop: 1'b1, sword: 8'h00, p: 3, exp_rx: 8'h81};
        vecs[3] = '{data: 8'h6E, lsb: 1'b1, cpha: 1'b0, loop: 1'b0, sword: 8'h5B, p: 2, exp_rx: 8'h5B};
        vecs[4] = '{data: 8'hF0, lsb: 1'b0, cpha: 1'b0, loop: 1'b0, sword: 8'h0F, p: 4, exp_rx: 8'h0F};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_brg_en", {31'd0, brg_en}, 32'd0);
        check("rst_sclk_en", {31'd0, brg_sclk_en}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) do_xfer($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Inputs toggled while busy must not disturb the latched word and mode.
        v = '{data: 8'hC3, lsb: 1'b0, cpha: 1'b0, loop: 1'b1, sword: 8'h00, p: 2, exp_rx: 8'hC3};
        do_xfer("toggle", v, 1'b1);

        // Abort in IDLE alone does nothing; together with tx_valid the accept still happens.
        abort = 1'b1;
        @(posedge clk); #1;
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        check("idle_abort_cs_n", {31'd0, cs_n}, 32'd1);
        v = '{data: 8'h5C, lsb: 1'b1, cpha: 1'b1, loop: 1'b1, sword: 8'h00, p: 2, exp_rx: 8'h5C};
        start(v);
        abort = 1'b0;
        finish("idle_abort_xfer", v, 1'b0);

        // Abort after the 5th counted edge.
        v = '{data: 8'h96, lsb: 1'b0, cpha: 1'b0, loop: 1'b1, sword: 8'h00, p: 2, exp_rx: 8'h96};
        start(v);
        wait_edges(5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_cs_n", {31'd0, cs_n}, 32'd1);
        check("abort_brg_en", {31'd0, brg_en}, 32'd0);
        check("abort_sclk_en", {31'd0, brg_sclk_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_tx_ready", {31'd0, tx_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_rx_valid", 32'(rxv_total - rxv0), 32'd0);
        check("abort_rx_data_kept", 32'(rx_data), 32'(prev_exp));

        // Reset in the middle of XFER.
        v = '{data: 8'h33, lsb: 1'b0, cpha: 1'b0, loop: 1'b1, sword: 8'h00, p: 2, exp_rx: 8'h33};
        start(v);
        wait_edges(3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("mid_rst_mosi", {31'd0, mosi}, 32'd0);
        check("mid_rst_brg_en", {31'd0, brg_en}, 32'd0);
        check("mid_rst_sclk_en", {31'd0, brg_sclk_en}, 32'd0);
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        v = '{data: 8'h5A, lsb: 1'b0, cpha: 1'b0, loop: 1'b1, sword: 8'h00, p: 2, exp_rx: 8'h5A};
        do_xfer("post_rst", v, 1'b0);

        // Back-to-back with tx_valid held high: 0x01 then 0xFF.
        g_sel = 4'd1; s_loop = 1'b1; s_cpha = 1'b0; s_lsb = 1'b0;
        cpha = 1'b0; lsb_first = 1'b0; tx_data = 8'h01; tx_valid = 1'b1;
        rxv0 = rxv_total; bad0 = ready_bad;
        @(posedge clk); #1;
        check("b2b_first_busy", {31'd0, busy}, 32'd1);
        tx_data = 8'hFF;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk); #1;
            if (rxv_total == rxv0 + 1) ok = 1'b1;
        end
        check("b2b_first_done", {31'd0, ok}, 32'd1);
        check("b2b_first_rx", 32'(last_rx), 32'h01);
        check("b2b_second_accepted", {31'd0, busy}, 32'd1);
        tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk); #1;
            if (rxv_total == rxv0 + 2) ok = 1'b1;
        end
        check("b2b_second_done", {31'd0, ok}, 32'd1);
        check("b2b_second_rx", 32'(last_rx), 32'hFF);
        check("b2b_cs_gap", 32'(last_gap), 32'd1);
        check("b2b_tx_ready_while_cs", 32'(ready_bad - bad0), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_pulse_count", 32'(rxv_total - rxv0), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
